wb_memory_responder: RTL
========================

WB_MEMORY_RESPONDER -- requirements
Module: wb_memory_responder

Interface
- REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
- REQ-002 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; must be a power of two, at least 2.
- REQ-003 SHALL have parameter WAIT_STATES, default 0, legal range 0..15: extra cycles inserted before the response.
- REQ-004 SHALL have port `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-005 SHALL have port `rst`, input, 1 bit: asynchronous, active-low reset.
- REQ-006 SHALL have port `wb_cyc`, input, 1 bit: bus cycle active.
- REQ-007 SHALL have port `wb_stb`, input, 1 bit: request strobe.
- REQ-008 SHALL have port `wb_we`, input, 1 bit: 1 = write, 0 = read.
- REQ-009 SHALL have port `wb_sel`, input, 4 bits: byte-lane enables, bit i selects dat[8i+7:8i].
- REQ-010 SHALL have port `wb_adr`, input, 32 bits: byte address.
- REQ-011 SHALL have port `wb_dat_mosi`, input, 32 bits: write data.
- REQ-012 SHALL have port `wb_dat_miso`, output, 32 bits: read data.
- REQ-013 SHALL have port `wb_ack`, output, 1 bit: successful completion.
- REQ-014 SHALL have port `wb_err`, output, 1 bit: error completion.

Function
- REQ-015 SHALL implement a three-state FSM:
  - IDLE: on wb_cyc&&wb_stb, latch adr/we/sel/dat_mosi; go to WAIT if WAIT_STATES>0, else RESP.
  - WAIT: decrement a 4-bit counter loaded with WAIT_STATES; go to RESP after exactly WAIT_STATES cycles.
  - RESP: one cycle, then IDLE unconditionally.
- REQ-016 SHALL assert exactly one of wb_ack/wb_err, for exactly one cycle, only in RESP; completion arrives WAIT_STATES+1 cycles after the accepting IDLE cycle.
- REQ-017 SHALL flag error when the latched address satisfies either condition:
  - adr[1:0] != 0;
  - adr < BASE_ADDR or adr >= BASE_ADDR+4*DEPTH_WORDS, computed without 32-bit wrap.
- REQ-018 SHALL write memory only in RESP with no error: each lane whose latched sel bit is 1 is updated; lanes with sel bit 0 keep their value; sel=0 is acked with no change.
- REQ-019 SHALL drive wb_dat_miso in RESP of a non-error read with the full word at index (adr-BASE_ADDR)>>2, ignoring sel; otherwise wb_dat_miso SHALL be 0.
- REQ-020 SHALL abort when wb_cyc or wb_stb is 0 in any WAIT cycle: return to IDLE next cycle, no write, no ack/err.
- REQ-021 SHALL NOT re-accept the request still presented during the RESP cycle: IDLE evaluates the bus one cycle after RESP, so back-to-back requests complete at most every WAIT_STATES+2 cycles.
- REQ-022 SHALL ignore wb_stb when wb_cyc is 0, and ignore input changes after acceptance (latched values are used).

Reset
- REQ-023 SHALL, while rst=0, immediately force state=IDLE, counter=0, wb_ack=0, wb_err=0, wb_dat_miso=0 and latched fields=0.
- REQ-024 SHALL leave memory contents unchanged by reset; they are undefined after power-up.
- REQ-025 SHALL discard any transfer in progress when reset is asserted: no write, no response after deassertion.

Structure
- REQ-026 SHALL take WB_ADDR_WIDTH=32, WB_DATA_WIDTH=32, WB_SEL_WIDTH=4 and the FSM state enum (IDLE/WAIT/RESP) from the shared package.
- REQ-027 SHALL place storage in a sub-module wb_memory_array: synchronous-write, byte-enable, DEPTH_WORDS x 32 array, combinational read.

Verification
- REQ-028 SHALL cover, with WAIT_STATES=0 and BASE_ADDR=0: write 0xDEADBEEF, sel=0xF, to 0x10, then read 0x10 -> each ack one cycle after accept; read data 0xDEADBEEF.
- REQ-029 SHALL cover: word 0x10 = 0xDEADBEEF; write 0x0000AA00 with sel=0x2 -> subsequent read returns 0xDEADAAEF.
- REQ-030 SHALL cover, with WAIT_STATES=3: read accepted at cycle N -> ack at N+4; ack and err both 0 at N+1..N+3.
- REQ-031 SHALL cover error cases -> err pulses one cycle, ack stays 0, memory unchanged:
  - access to address 0x12 (misaligned);
  - access to address 4*DEPTH_WORDS (out of range).
- REQ-032 SHALL cover, with WAIT_STATES=3: write to 0x20, stb dropped at the second WAIT cycle -> no ack/err; later read of 0x20 returns the prior value.
- REQ-033 SHALL cover: rst pulsed low mid-WAIT -> outputs 0 within the same cycle; no response after release; write not performed.

Source files
------------

// File: rtl/wb_memory_responder_pkg.sv
// ----------------------------------------------------------------------------
// wb_memory_responder_pkg
// Shared definitions for the Wishbone memory responder slice.
//   - Bus widths (address, data, byte-select).
//   - FSM state enum used by the responder top.
//   - lane_merge helper: byte-lane merge of write data into a stored word.
// No ports (package).
// ----------------------------------------------------------------------------
package wb_memory_responder_pkg;

   localparam int WB_ADDR_WIDTH = 32;
   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_SEL_WIDTH  = 4;

   // Responder FSM: wait for a request, optionally burn wait states,
   // then present a single-cycle completion.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Replace only the byte lanes whose select bit is set; all other lanes
   // keep the value already stored.
   function automatic logic [WB_DATA_WIDTH-1:0] lane_merge(
      input logic [WB_DATA_WIDTH-1:0] old_word,
      input logic [WB_DATA_WIDTH-1:0] new_word,
      input logic [WB_SEL_WIDTH-1:0]  sel
   );
      logic [WB_DATA_WIDTH-1:0] merged;
      merged = old_word;
      for (int i = 0; i < WB_SEL_WIDTH; i++) begin
         if (sel[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/wb_memory_responder_if.sv
// ----------------------------------------------------------------------------
// wb_memory_responder_if
// Wishbone classic bus bundle between a master and the memory responder.
//   wb_cyc       master -> slave  bus cycle active
//   wb_stb       master -> slave  request strobe
//   wb_we        master -> slave  1 = write, 0 = read
//   wb_sel[3:0]  master -> slave  byte-lane enables
//   wb_adr[31:0] master -> slave  byte address
//   wb_dat_mosi  master -> slave  write data
//   wb_dat_miso  slave -> master  read data
//   wb_ack       slave -> master  successful completion
//   wb_err       slave -> master  error completion
// Modports: master (drives requests), slave (drives completions).
// ----------------------------------------------------------------------------
interface wb_memory_responder_if;
   import wb_memory_responder_pkg::*;

   logic                     wb_cyc;
   logic                     wb_stb;
   logic                     wb_we;
   logic [WB_SEL_WIDTH-1:0]  wb_sel;
   logic [WB_ADDR_WIDTH-1:0] wb_adr;
   logic [WB_DATA_WIDTH-1:0] wb_dat_mosi;
   logic [WB_DATA_WIDTH-1:0] wb_dat_miso;
   logic                     wb_ack;
   logic                     wb_err;

   modport master (
      output wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_mosi,
      input  wb_dat_miso, wb_ack, wb_err
   );

   modport slave (
      input  wb_cyc, wb_stb, wb_we, wb_sel, wb_adr, wb_dat_mosi,
      output wb_dat_miso, wb_ack, wb_err
   );

endinterface

// File: rtl/wb_memory_array.sv
// ----------------------------------------------------------------------------
// wb_memory_array
// DEPTH_WORDS x 32-bit storage with byte-enable synchronous write and
// combinational read. Contents are not reset.
//   clk    clock, write happens on rising edge
//   we     write enable
//   sel    byte-lane enables for the write
//   idx    word index (shared by read and write)
//   wdata  write data
//   rdata  word currently stored at idx
// ----------------------------------------------------------------------------
module wb_memory_array
   import wb_memory_responder_pkg::*;
#(
   parameter  int DEPTH_WORDS = 1024,
   localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [WB_SEL_WIDTH-1:0]  sel,
   input  logic [IDX_W-1:0]         idx,
   input  logic [WB_DATA_WIDTH-1:0] wdata,
   output logic [WB_DATA_WIDTH-1:0] rdata
);

   logic [WB_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

   // Byte-lane write: unselected lanes are rewritten with their own value,
   // so a write with sel=0 leaves the word untouched.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= lane_merge(mem[idx], wdata, sel);
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/wb_memory_responder.sv
// ----------------------------------------------------------------------------
// wb_memory_responder
// Wishbone classic slave backed by a word memory. A request is latched in
// IDLE, optionally held for WAIT_STATES cycles, then completed with a single
// ack (or err for a misaligned / out-of-window address) in RESP.
//   clk  clock
//   rst  asynchronous active-low reset
//   bus  Wishbone slave modport (see wb_memory_responder_if)
// Parameters:
//   BASE_ADDR    byte address of word 0
//   DEPTH_WORDS  number of 32-bit words (power of two, >= 2)
//   WAIT_STATES  extra cycles before the response (0..15)
// ----------------------------------------------------------------------------
module wb_memory_responder
   import wb_memory_responder_pkg::*;
#(
   parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter int                       DEPTH_WORDS = 1024,
   parameter int                       WAIT_STATES = 0
) (
   input logic                  clk,
   input logic                  rst,
   wb_memory_responder_if.slave bus
);

   localparam int                     IDX_W     = $clog2(DEPTH_WORDS);
   localparam int                     WIDE_W    = WB_ADDR_WIDTH + 2;
   localparam logic [3:0]             WAIT_LOAD = 4'(WAIT_STATES);
   // Window bounds carried in two extra bits so BASE_ADDR + 4*DEPTH_WORDS
   // cannot wrap around the 32-bit address space.
   localparam logic [WIDE_W-1:0]      ADDR_LO   = {2'b00, BASE_ADDR};
   localparam logic [WIDE_W-1:0]      ADDR_HI   = ADDR_LO + (WIDE_W'(DEPTH_WORDS) << 2);

   state_t                     state;
   state_t                     next_state;
   logic [3:0]                 wait_cnt;
   logic [3:0]                 next_cnt;
   logic                       accept;
   logic                       req_active;
   logic                       in_resp;
   logic                       addr_err;
   logic                       mem_we;
   logic [IDX_W-1:0]           mem_idx;
   logic [WB_DATA_WIDTH-1:0]   mem_rdata;

   logic [WB_ADDR_WIDTH-1:0]   lat_adr;
   logic [WB_DATA_WIDTH-1:0]   lat_dat;
   logic [WB_SEL_WIDTH-1:0]    lat_sel;
   logic                       lat_we;

   assign req_active = bus.wb_cyc && bus.wb_stb;

   // State register and wait counter; reset drops any transfer in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_cnt;
      end
   end

   // Next-state logic. WAIT leaves for RESP on the cycle the counter reads 1,
   // giving exactly WAIT_STATES cycles in WAIT; losing cyc or stb there
   // abandons the request. RESP always returns to IDLE, so a request still
   // held during RESP is only seen again one cycle later.
   always_comb begin
      next_state = state;
      next_cnt   = wait_cnt;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (req_active) begin
               accept = 1'b1;
               if (WAIT_LOAD != 4'd0) begin
                  next_state = WAIT;
                  next_cnt   = WAIT_LOAD;
               end else begin
                  next_state = RESP;
               end
            end
         end
         WAIT: begin
            if (!req_active) begin
               next_state = IDLE;
               next_cnt   = 4'd0;
            end else if (wait_cnt == 4'd1) begin
               next_state = RESP;
               next_cnt   = 4'd0;
            end else begin
               next_cnt = wait_cnt - 4'd1;
            end
         end
         RESP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
            next_cnt   = 4'd0;
         end
      endcase
   end

   // Request capture: everything the response needs is frozen at acceptance
   // so later bus changes have no effect on the transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lat_adr <= '0;
         lat_dat <= '0;
         lat_sel <= '0;
         lat_we  <= 1'b0;
      end else if (accept) begin
         lat_adr <= bus.wb_adr;
         lat_dat <= bus.wb_dat_mosi;
         lat_sel <= bus.wb_sel;
         lat_we  <= bus.wb_we;
      end
   end

   // Address checks on the latched address: word alignment and the memory
   // window, compared at the wider width.
   assign addr_err = (lat_adr[1:0] != 2'b00)
                  || ({2'b00, lat_adr} <  ADDR_LO)
                  || ({2'b00, lat_adr} >= ADDR_HI);

   assign in_resp = (state == RESP);
   assign mem_we  = in_resp && lat_we && !addr_err;
   assign mem_idx = IDX_W'((lat_adr - BASE_ADDR) >> 2);

   wb_memory_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .sel   (lat_sel),
      .idx   (mem_idx),
      .wdata (lat_dat),
      .rdata (mem_rdata)
   );

   // Completion outputs decode only registered state, so reset clears them
   // immediately and they never follow the bus inputs combinationally.
   assign bus.wb_ack      = in_resp && !addr_err;
   assign bus.wb_err      = in_resp && addr_err;
   assign bus.wb_dat_miso = (in_resp && !lat_we && !addr_err) ? mem_rdata : '0;

endmodule
